// File: rtl/glb_store_dma_ctrl.sv
// glb_store_dma_ctrl: per-GLB-tile store DMA sequencer.
// Pops queued store headers (byte start address, 16-bit word count) and packs the
// incoming CGRA stream into bank-word write packets. One done pulse per header.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   hdr_push/start_addr/num   : header enqueue; hdr_full / hdr_count report queue state
//   stream_data_f2g/valid     : 16-bit stream words from the CGRA (no backpressure)
//   wr_en/strb/addr/data      : bank write packet, one cycle after the flushing word
//   busy                      : a header is being streamed
//   st_done_pulse             : one cycle per completed header
//   drop_sticky               : a stream word arrived while idle
module glb_store_dma_ctrl #(
    parameter int unsigned QUEUE_DEPTH         = 4,
    parameter int unsigned GLB_ADDR_WIDTH      = 22,
    parameter int unsigned BANK_DATA_WIDTH     = 64,
    parameter int unsigned CGRA_DATA_WIDTH     = 16,
    parameter int unsigned MAX_NUM_WORDS_WIDTH = 21
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               hdr_push,
    input  logic [GLB_ADDR_WIDTH-1:0]          hdr_start_addr,
    input  logic [MAX_NUM_WORDS_WIDTH-1:0]     hdr_num_words,
    output logic                               hdr_full,
    output logic [$clog2(QUEUE_DEPTH):0]       hdr_count,
    input  logic [CGRA_DATA_WIDTH-1:0]         stream_data_f2g,
    input  logic                               stream_data_valid_f2g,
    output logic                               wr_en,
    output logic [BANK_DATA_WIDTH/8-1:0]       wr_strb,
    output logic [GLB_ADDR_WIDTH-1:0]          wr_addr,
    output logic [BANK_DATA_WIDTH-1:0]         wr_data,
    output logic                               busy,
    output logic                               st_done_pulse,
    output logic                               drop_sticky
);

    localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int unsigned NUM_LANES = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
    localparam int unsigned LANE_W    = $clog2(NUM_LANES);
    localparam int unsigned STRB_W    = BANK_DATA_WIDTH / 8;
    localparam int unsigned LANE_STRB = CGRA_DATA_WIDTH / 8;
    localparam int unsigned BYTE_W    = $clog2(STRB_W);

    typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

    // Header queue storage and pointers
    logic [GLB_ADDR_WIDTH-1:0]      q_addr_q [QUEUE_DEPTH];
    logic [MAX_NUM_WORDS_WIDTH-1:0] q_num_q  [QUEUE_DEPTH];
    logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           full_q;

    // Transfer state
    state_t                         state_q;
    logic [GLB_ADDR_WIDTH-1:0]      cur_addr_q;
    logic [MAX_NUM_WORDS_WIDTH-1:0] remaining_q;
    logic [BANK_DATA_WIDTH-1:0]     acc_data_q, merge_data_d;
    logic [STRB_W-1:0]              acc_strb_q, merge_strb_d;

    // Registered outputs
    logic                           wr_en_q, done_q, drop_q;
    logic [STRB_W-1:0]              wr_strb_q;
    logic [GLB_ADDR_WIDTH-1:0]      wr_addr_q;
    logic [BANK_DATA_WIDTH-1:0]     wr_data_q;

    logic                           pop_c, push_c, last_c, flush_c;
    logic [LANE_W-1:0]              lane_c;

    // Pop only from IDLE; a push into a full queue is accepted only alongside a pop
    assign pop_c   = (state_q == ST_IDLE) && (count_q != '0);
    assign push_c  = hdr_push && ((count_q != CNT_W'(QUEUE_DEPTH)) || pop_c);
    assign count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    assign lane_c  = cur_addr_q[LANE_W:1];
    assign last_c  = (remaining_q == MAX_NUM_WORDS_WIDTH'(1));
    assign flush_c = (lane_c == '1) || last_c;

    // Accumulator with the current stream word merged into its lane
    always_comb begin
        merge_data_d = acc_data_q;
        merge_strb_d = acc_strb_q;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (lane_c == LANE_W'(l)) begin
                merge_data_d[l*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] = stream_data_f2g;
                merge_strb_d[l*LANE_STRB +: LANE_STRB]             = '1;
            end
        end
    end

    // Queue entry storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            q_addr_q[wr_ptr_q] <= hdr_start_addr;
            q_num_q[wr_ptr_q]  <= hdr_num_words;
        end
    end

    // Queue control, transfer FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_strb_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_strb_q <= '0;
            done_q    <= 1'b0;

            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(QUEUE_DEPTH));

            case (state_q)
                ST_IDLE: begin
                    if (stream_data_valid_f2g) drop_q <= 1'b1;
                    if (pop_c) begin
                        if (q_num_q[rd_ptr_q] == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cur_addr_q  <= q_addr_q[rd_ptr_q] & ~GLB_ADDR_WIDTH'(1);
                            remaining_q <= q_num_q[rd_ptr_q];
                            acc_data_q  <= '0;
                            acc_strb_q  <= '0;
                            state_q     <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (stream_data_valid_f2g) begin
                        cur_addr_q  <= cur_addr_q + GLB_ADDR_WIDTH'(2);
                        remaining_q <= remaining_q - MAX_NUM_WORDS_WIDTH'(1);
                        if (flush_c) begin
                            wr_en_q    <= 1'b1;
                            wr_strb_q  <= merge_strb_d;
                            wr_data_q  <= merge_data_d;
                            wr_addr_q  <= {cur_addr_q[GLB_ADDR_WIDTH-1:BYTE_W], {BYTE_W{1'b0}}};
                            acc_data_q <= '0;
                            acc_strb_q <= '0;
                        end else begin
                            acc_data_q <= merge_data_d;
                            acc_strb_q <= merge_strb_d;
                        end
                        if (last_c) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hdr_full      = full_q;
    assign hdr_count     = count_q;
    assign wr_en         = wr_en_q;
    assign wr_strb       = wr_strb_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = (state_q == ST_ACTIVE);
    assign st_done_pulse = done_q;
    assign drop_sticky   = drop_q;

endmodule

// File: tb/tb_glb_store_dma_ctrl.sv
// Self-checking bench for glb_store_dma_ctrl: a byte-level reference model tracks
// expected outputs every cycle; directed scenarios also pin literal packet values.
module tb_glb_store_dma_ctrl;

    localparam int unsigned QD = 4;

    logic        clk;
    logic        reset;
    logic        hdr_push;
    logic [21:0] hdr_start_addr;
    logic [20:0] hdr_num_words;
    logic        hdr_full;
    logic [2:0]  hdr_count;
    logic [15:0] stream_data_f2g;
    logic        stream_data_valid_f2g;
    logic        wr_en;
    logic [7:0]  wr_strb;
    logic [21:0] wr_addr;
    logic [63:0] wr_data;
    logic        busy;
    logic        st_done_pulse;
    logic        drop_sticky;

    glb_store_dma_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .hdr_push              (hdr_push),
        .hdr_start_addr        (hdr_start_addr),
        .hdr_num_words         (hdr_num_words),
        .hdr_full              (hdr_full),
        .hdr_count             (hdr_count),
        .stream_data_f2g       (stream_data_f2g),
        .stream_data_valid_f2g (stream_data_valid_f2g),
        .wr_en                 (wr_en),
        .wr_strb               (wr_strb),
        .wr_addr               (wr_addr),
        .wr_data               (wr_data),
        .busy                  (busy),
        .st_done_pulse         (st_done_pulse),
        .drop_sticky           (drop_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [21:0] a; logic [20:0] n; } hdr_t;
    typedef struct { logic [21:0] a; logic [7:0] s; logic [63:0] d; } pkt_t;

    hdr_t        hq[$];
    bit          model_ok = 0;
    bit          m_active = 0;
    logic [21:0] m_cur;
    int          m_rem;
    logic [7:0]  m_byte [8];
    bit          m_bm   [8];
    logic        e_wr_en, e_done, e_drop, e_busy, e_full;
    logic [7:0]  e_strb;
    logic [21:0] e_addr;
    logic [63:0] e_data;
    int          e_count;

    always @(posedge clk) begin
        bit          do_pop, do_push;
        hdr_t        h;
        logic [21:0] nxt;
        int          off;
        if (reset) begin
            hq.delete();
            m_active = 0; m_rem = 0; m_cur = '0;
            for (int b = 0; b < 8; b++) begin m_byte[b] = '0; m_bm[b] = 0; end
            e_wr_en = 0; e_strb = '0; e_addr = '0; e_data = '0; e_done = 0;
            e_drop = 0; e_busy = 0; e_full = 0; e_count = 0;
            model_ok = 1;
        end else begin
            e_wr_en = 0; e_strb = '0; e_done = 0;
            do_pop  = !m_active && (hq.size() != 0);
            do_push = hdr_push && ((hq.size() < QD) || do_pop);
            if (!m_active) begin
                if (stream_data_valid_f2g) e_drop = 1;
                if (do_pop) begin
                    h = hq.pop_front();
                    if (h.n == 0) e_done = 1;
                    else begin
                        m_active = 1;
                        m_cur    = h.a & ~22'h1;
                        m_rem    = int'(h.n);
                        for (int b = 0; b < 8; b++) begin m_byte[b] = '0; m_bm[b] = 0; end
                    end
                end
            end else if (stream_data_valid_f2g) begin
                off = int'(m_cur[2:0]);
                m_byte[off]   = stream_data_f2g[7:0];
                m_byte[off+1] = stream_data_f2g[15:8];
                m_bm[off]     = 1;
                m_bm[off+1]   = 1;
                nxt   = m_cur + 22'd2;
                m_rem = m_rem - 1;
                // bank word is complete when the next byte address leaves it, or the header ends
                if ((nxt[21:3] != m_cur[21:3]) || (m_rem == 0)) begin
                    e_wr_en = 1;
                    e_addr  = {m_cur[21:3], 3'b000};
                    for (int b = 0; b < 8; b++) begin
                        e_strb[b]      = m_bm[b];
                        e_data[b*8 +: 8] = m_bm[b] ? m_byte[b] : 8'h00;
                        m_byte[b] = '0; m_bm[b] = 0;
                    end
                end
                if (m_rem == 0) begin e_done = 1; m_active = 0; end
                m_cur = nxt;
            end
            if (do_push) hq.push_back('{a: hdr_start_addr, n: hdr_num_words});
            e_count = hq.size();
            e_full  = (hq.size() == QD);
            e_busy  = m_active;
        end
    end

    // ---------------- compare process + observed packet log ----------------
    pkt_t log_q[$];
    int   ndone = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("wr_en",         64'(wr_en),         64'(e_wr_en));
            chk("wr_strb",       64'(wr_strb),       64'(e_strb));
            chk("wr_addr",       64'(wr_addr),       64'(e_addr));
            chk("wr_data",       wr_data,            e_data);
            chk("busy",          64'(busy),          64'(e_busy));
            chk("st_done_pulse", 64'(st_done_pulse), 64'(e_done));
            chk("drop_sticky",   64'(drop_sticky),   64'(e_drop));
            chk("hdr_full",      64'(hdr_full),      64'(e_full));
            chk("hdr_count",     64'(hdr_count),     64'(e_count));
            if (wr_en === 1'b1) log_q.push_back('{a: wr_addr, s: wr_strb, d: wr_data});
            if (st_done_pulse === 1'b1) ndone++;
        end
    end

    function automatic pkt_t get_pkt(input int i);
        pkt_t p;
        p = '{a: '0, s: '0, d: '0};
        if (i < log_q.size()) p = log_q[i];
        return p;
    endfunction

    task automatic chk_pkt(input string nm, input int i, input logic [21:0] a,
                           input logic [7:0] s, input logic [63:0] d);
        pkt_t p;
        p = get_pkt(i);
        chk({nm, ".addr"}, 64'(p.a), 64'(a));
        chk({nm, ".strb"}, 64'(p.s), 64'(s));
        chk({nm, ".data"}, p.d, d);
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input bit p, input logic [21:0] a, input logic [20:0] n,
                         input bit v, input logic [15:0] d);
        hdr_push = p; hdr_start_addr = a; hdr_num_words = n;
        stream_data_valid_f2g = v; stream_data_f2g = d;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0);
    endtask

    task automatic push_hdr(input logic [21:0] a, input logic [20:0] n);
        drive(1, a, n, 0, '0);
    endtask

    // Stream n words base + i*step, waiting for the DUT to be busy before each word
    task automatic stream(input int n, input logic [15:0] base, input logic [15:0] step, input int gap);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (busy !== 1'b1 && guard < 200) begin idle(1); guard++; end
            if (guard >= 200) begin
                n_checks++;
                $display("FAIL busy_wait: got busy=%b expected 1 within 200 cycles", busy);
            end
            drive(0, '0, '0, 1, base + 16'(i) * step);
            if (i != n - 1) idle(gap);
        end
    endtask

    task automatic start_test;
        log_q.delete();
        ndone = 0;
    endtask

    initial begin
        reset = 1'b1;
        hdr_push = 0; hdr_start_addr = '0; hdr_num_words = '0;
        stream_data_valid_f2g = 0; stream_data_f2g = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst.wr_en", 64'(wr_en), 64'd0);
        chk("rst.count", 64'(hdr_count), 64'd0);
        chk("rst.busy",  64'(busy), 64'd0);
        reset = 1'b0;
        idle(2);

        // aligned, 4 words
        start_test();
        push_hdr(22'h000100, 21'd4);
        stream(4, 16'h1111, 16'h1111, 0);
        idle(3);
        chk("aligned.npkt", 64'(log_q.size()), 64'd1);
        chk_pkt("aligned", 0, 22'h000100, 8'hFF, 64'h4444_3333_2222_1111);
        chk("aligned.ndone", 64'(ndone), 64'd1);
        chk("aligned.busy", 64'(busy), 64'd0);

        // unaligned, 3 words
        start_test();
        push_hdr(22'h000106, 21'd3);
        stream(3, 16'hAAAA, 16'h1111, 0);
        idle(3);
        chk("unal.npkt", 64'(log_q.size()), 64'd2);
        chk_pkt("unal0", 0, 22'h000100, 8'hC0, 64'hAAAA_0000_0000_0000);
        chk_pkt("unal1", 1, 22'h000108, 8'h0F, 64'h0000_0000_CCCC_BBBB);
        chk("unal.ndone", 64'(ndone), 64'd1);

        // gapped stream, 8 words
        start_test();
        push_hdr(22'h000000, 21'd8);
        stream(8, 16'h0001, 16'h0001, 1);
        idle(3);
        chk("gap.npkt", 64'(log_q.size()), 64'd2);
        chk_pkt("gap0", 0, 22'h000000, 8'hFF, 64'h0004_0003_0002_0001);
        chk_pkt("gap1", 1, 22'h000008, 8'hFF, 64'h0008_0007_0006_0005);

        // queue full and zero-length header
        start_test();
        push_hdr(22'h000200, 21'd8);
        idle(2);
        push_hdr(22'h000000, 21'd0);
        push_hdr(22'h000010, 21'd1);
        push_hdr(22'h000020, 21'd1);
        push_hdr(22'h000030, 21'd1);
        chk("full.flag",  64'(hdr_full),  64'd1);
        chk("full.count", 64'(hdr_count), 64'd4);
        push_hdr(22'h000040, 21'd1);
        chk("full.ignored", 64'(hdr_count), 64'd4);
        stream(8, 16'h0100, 16'h0001, 0);
        for (int k = 0; k < 3; k++) stream(1, 16'hD0D0, 16'h0000, 0);
        idle(4);
        chk("full.npkt",  64'(log_q.size()), 64'd5);
        chk_pkt("full2", 2, 22'h000010, 8'h03, 64'h0000_0000_0000_D0D0);
        chk_pkt("full4", 4, 22'h000030, 8'h03, 64'h0000_0000_0000_D0D0);
        chk("full.ndone", 64'(ndone), 64'd5);
        chk("full.empty", 64'(hdr_count), 64'd0);
        chk("full.busy",  64'(busy), 64'd0);

        // address wrap, then a dropped word
        start_test();
        chk("drop.before", 64'(drop_sticky), 64'd0);
        push_hdr(22'h3FFFFC, 21'd4);
        stream(4, 16'h5000, 16'h0001, 0);
        idle(2);
        chk("wrap.npkt", 64'(log_q.size()), 64'd2);
        chk_pkt("wrap0", 0, 22'h3FFFF8, 8'hF0, 64'h5001_5000_0000_0000);
        chk_pkt("wrap1", 1, 22'h000000, 8'h0F, 64'h0000_0000_5003_5002);
        drive(0, '0, '0, 1, 16'hDEAD);
        idle(1);
        chk("drop.after", 64'(drop_sticky), 64'd1);

        // reset mid-transfer
        start_test();
        push_hdr(22'h000100, 21'd4);
        stream(2, 16'h6000, 16'h0001, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("mrst.wr_en", 64'(wr_en), 64'd0);
        chk("mrst.busy",  64'(busy), 64'd0);
        chk("mrst.count", 64'(hdr_count), 64'd0);
        chk("mrst.drop",  64'(drop_sticky), 64'd0);
        chk("mrst.npkt",  64'(log_q.size()), 64'd0);
        push_hdr(22'h000500, 21'd2);
        stream(2, 16'h7000, 16'h0001, 0);
        idle(2);
        chk("mrst.npkt2", 64'(log_q.size()), 64'd1);
        chk_pkt("mrst0", 0, 22'h000500, 8'h0F, 64'h0000_0000_7001_7000);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 5) == 0, 22'($urandom), 21'($urandom_range(0, 9)),
                  $urandom_range(0, 3) != 0, 16'($urandom));
        end
        reset = 1'b0;
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
